regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file with a built-in pending-write scoreboard. It serves as the successor register file for dual-writeback pipelines.
- Read ports: NUM_RD, combinational, with write bypass.
- Write ports: two, with fixed priority (port 1 = load/late writeback, port 0 = ALU writeback).
- Scoreboard: per-register pending bits, set at issue and cleared at writeback, so the decode stage can stall on RAW hazards.

Parameters:
DATA_WIDTH, 32, width of each register.
ADDR_WIDTH, 5, register address width; the array holds 2**ADDR_WIDTH registers.
NUM_RD, 2, number of read ports (1..4).
ZERO_REG, 1, 1 = register 0 is hardwired to zero, never written and never pending.
BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return array contents only.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
rd_addr_i  in  NUM_RD*ADDR_WIDTH  read addresses; port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH].
rd_data_o  out  NUM_RD*DATA_WIDTH  read data, packed the same way.
rd_busy_o  out  NUM_RD  1 = the addressed register still has a pending producer.
wr0_en_i  in  1  write port 0 enable.
wr0_addr_i  in  ADDR_WIDTH  write port 0 address.
wr0_data_i  in  DATA_WIDTH  write port 0 data.
wr1_en_i  in  1  write port 1 enable (higher priority).
wr1_addr_i  in  ADDR_WIDTH  write port 1 address.
wr1_data_i  in  DATA_WIDTH  write port 1 data.
issue_en_i  in  1  mark a destination register as pending.
issue_addr_i  in  ADDR_WIDTH  destination register being issued.
flush_i  in  1  clear all pending bits (pipeline flush).
busy_cnt_o  out  ADDR_WIDTH+1  registered count of set pending bits.

Behaviour:
- Reset: sync; when rst_n=0 at a clock edge:
  - all registers <= 0, all pending bits <= 0, busy_cnt_o <= 0;
  - all writes, issues and flushes in that cycle are ignored.
- Reads while rst_n=0: rd_data_o = 0 and rd_busy_o = 0, combinationally, regardless of stored state.
- Write (rising edge):
  - wrN_en_i=1 writes wrN_data_i to wrN_addr_i.
  - Same address on both ports in the same cycle: port 1 data is stored.
  - ZERO_REG=1: writes to address 0 are dropped.
- Read (combinational, each port k, priority order):
  1. rst_n=0 -> 0;
  2. ZERO_REG=1 and addr=0 -> 0;
  3. BYPASS=1 and wr1_en_i and wr1_addr_i=addr -> wr1_data_i;
  4. BYPASS=1 and wr0_en_i and wr0_addr_i=addr -> wr0_data_i;
  5. otherwise array[addr].
  Read latency is 0 cycles; written data appears in the array on the cycle after the write edge.
- Pending bits, next-state per register r, in this priority order:
  1. issue_en_i and issue_addr_i=r -> 1. A new producer wins over a same-cycle writeback and over flush_i.
  2. flush_i -> 0.
  3. (wr0_en_i and wr0_addr_i=r) or (wr1_en_i and wr1_addr_i=r) -> 0.
  4. otherwise hold.
  - ZERO_REG=1: register 0 never becomes pending.
  - A writeback to a register that is not pending is legal and leaves its pending bit at 0.
- rd_busy_o[k], combinational:
  - equals pending[addr] with the following overrides;
  - forced to 0 when ZERO_REG=1 and addr=0;
  - forced to 0 when BYPASS=1 and either write port hits addr this cycle, because the forwarded data is valid.
- busy_cnt_o: registered popcount of the next-state pending vector, so it equals the number of set pending bits from the cycle after any update. Maximum value is 2**ADDR_WIDTH - ZERO_REG.
- No overflow/underflow conditions exist; the bits are set/clear, not counters.

Test Plan:
- Reset then read: hold rst_n=0 for 2 cycles, release; read x5 on all ports -> rd_data_o=0, rd_busy_o=0, busy_cnt_o=0.
- Bypass priority: wr0 writes x3=0x11, wr1 writes x3=0x22 in the same cycle.
  - Same cycle: read x3 -> 0x22.
  - Next cycle, no writes: read x3 -> 0x22 from the array.
- x0 protection: issue x0; write x0=0xDEAD -> read x0 = 0, rd_busy=0, busy_cnt_o unchanged.
- Scoreboard:
  - issue x7 -> busy_cnt_o=1 and rd_busy=1 for x7 on the next cycle.
  - wr0 writes x7=0x5 -> rd_busy=0 in that cycle (bypass); pending bit cleared and busy_cnt_o=0 on the next cycle.
- Issue vs writeback collision: x9 pending; issue x9 and wr1 writes x9=0x77 in the same cycle -> x9 stays pending, array x9=0x77, busy_cnt_o=1.
- Flush and reset mid-operation:
  - Pend x1, x2, x3, then flush with issue x4 in the same cycle -> only x4 pending, busy_cnt_o=1.
  - Then rst_n=0 with a concurrent wr0 to x4 -> write ignored; all state cleared.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
//
// Multi-port integer register file with a built-in pending-write scoreboard,
// meant for pipelines with two writeback paths (ALU on port 0, load / late
// writeback on port 1). Decode reads operands and the per-register busy
// flag combinationally and stalls on RAW hazards while a producer is still
// outstanding.
//
// Ports:
//   clk, rst_n        clock (rising edge) and synchronous active-low reset
//   rd_addr_i         NUM_RD packed read addresses, port k at [k*AW +: AW]
//   rd_data_o         NUM_RD packed read data (write-bypassed when BYPASS=1)
//   rd_busy_o         per read port: addressed register still pending
//   wr0_*             write port 0 (ALU writeback, lower priority)
//   wr1_*             write port 1 (load writeback, higher priority)
//   issue_en_i/addr   mark a destination register as pending
//   flush_i           clear every pending bit
//   busy_cnt_o        registered number of pending registers
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]              rd_busy_o,
    input  logic                           wr0_en_i,
    input  logic [ADDR_WIDTH-1:0]          wr0_addr_i,
    input  logic [DATA_WIDTH-1:0]          wr0_data_i,
    input  logic                           wr1_en_i,
    input  logic [ADDR_WIDTH-1:0]          wr1_addr_i,
    input  logic [DATA_WIDTH-1:0]          wr1_data_i,
    input  logic                           issue_en_i,
    input  logic [ADDR_WIDTH-1:0]          issue_addr_i,
    input  logic                           flush_i,
    output logic [ADDR_WIDTH:0]            busy_cnt_o
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_d;
    logic [ADDR_WIDTH:0]   busy_cnt_q;
    logic [ADDR_WIDTH:0]   busy_cnt_d;

    logic wr0_ok;
    logic wr1_ok;

    // Writes to x0 are dropped when it is hardwired to zero.
    assign wr0_ok = wr0_en_i && !((ZERO_REG != 0) && (wr0_addr_i == ZERO_ADDR));
    assign wr1_ok = wr1_en_i && !((ZERO_REG != 0) && (wr1_addr_i == ZERO_ADDR));

    // Array next state: port 1 is applied last so it wins a same-address
    // collision with port 0.
    always_comb begin
        regs_d = regs_q;
        if (wr0_ok) begin
            regs_d[wr0_addr_i] = wr0_data_i;
        end
        if (wr1_ok) begin
            regs_d[wr1_addr_i] = wr1_data_i;
        end
    end

    // Scoreboard next state. A new issue beats both flush and a same-cycle
    // writeback, since the issued instruction is a younger producer than
    // whatever is writing back now.
    always_comb begin
        pending_d  = pending_q;
        busy_cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            logic issue_hit;
            logic wb_hit;
            issue_hit = issue_en_i && (issue_addr_i == ADDR_WIDTH'(r));
            wb_hit    = (wr0_en_i && (wr0_addr_i == ADDR_WIDTH'(r))) ||
                        (wr1_en_i && (wr1_addr_i == ADDR_WIDTH'(r)));
            if (issue_hit) begin
                pending_d[r] = 1'b1;
            end else if (flush_i) begin
                pending_d[r] = 1'b0;
            end else if (wb_hit) begin
                pending_d[r] = 1'b0;
            end
            if ((ZERO_REG != 0) && (r == 0)) begin
                pending_d[r] = 1'b0;
            end
            busy_cnt_d = busy_cnt_d + (ADDR_WIDTH + 1)'(pending_d[r]);
        end
    end

    // State registers with synchronous reset; everything presented during a
    // reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            pending_q  <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pending_q  <= pending_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt_o = busy_cnt_q;

    // Read ports. Forwarded write data is already valid, so a bypass hit
    // also suppresses the busy flag for that port.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_WIDTH-1:0] addr;
            logic                  hit0;
            logic                  hit1;
            addr = rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            hit1 = (BYPASS != 0) && wr1_en_i && (wr1_addr_i == addr);
            hit0 = (BYPASS != 0) && wr0_en_i && (wr0_addr_i == addr);
            if (!rst_n) begin
                rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ((ZERO_REG != 0) && (addr == ZERO_ADDR)) begin
                rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if (hit1) begin
                rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = wr1_data_i;
            end else if (hit0) begin
                rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = wr0_data_i;
            end else begin
                rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[addr];
                rd_busy_o[k] = pending_q[addr];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp_sb
//
// Self-checking bench for regfile_mp_sb (default parameters, two read
// ports). A behavioural model holds the register contents and pending set
// as plain arrays and is advanced once per clock edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NREGS = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wr0_en;
    logic [AW-1:0]     wr0_addr;
    logic [DW-1:0]     wr0_data;
    logic              wr1_en;
    logic [AW-1:0]     wr1_addr;
    logic [DW-1:0]     wr1_data;
    logic              issue_en;
    logic [AW-1:0]     issue_addr;
    logic              flush;
    logic [AW:0]       busy_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_mem  [NREGS];
    logic          m_pend [NREGS];

    regfile_mp_sb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .wr0_en_i     (wr0_en),
        .wr0_addr_i   (wr0_addr),
        .wr0_data_i   (wr0_data),
        .wr1_en_i     (wr1_en),
        .wr1_addr_i   (wr1_addr),
        .wr1_data_i   (wr1_data),
        .issue_en_i   (issue_en),
        .issue_addr_i (issue_addr),
        .flush_i      (flush),
        .busy_cnt_o   (busy_cnt)
    );

    always #5 clk = ~clk;

    // Model view of a read: reset, x0, wr1 forward, wr0 forward, array.
    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (!rst_n || a == 0) return '0;
        if (wr1_en && wr1_addr == a) return wr1_data;
        if (wr0_en && wr0_addr == a) return wr0_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (!rst_n || a == 0) return 1'b0;
        if ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a)) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int r = 0; r < NREGS; r++) n += int'(m_pend[r]);
        return n;
    endfunction

    // Advance the model with the inputs currently applied, then clock.
    task automatic tick();
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                m_mem[r]  = '0;
                m_pend[r] = 1'b0;
            end
        end else begin
            if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
            if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] = wr1_data;
            if (wr0_en) m_pend[wr0_addr] = 1'b0;
            if (wr1_en) m_pend[wr1_addr] = 1'b0;
            if (flush) for (int r = 0; r < NREGS; r++) m_pend[r] = 1'b0;
            if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr0_en = 0; wr0_addr = 0; wr0_data = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0;
        issue_en = 0; issue_addr = 0; flush = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        rd_addr = {5'd5, 5'd5};
        tick();
        tick();
        rst_n = 1;
        #1;
        checks++;
        if (rd_data !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_rd_data: got %h expected 0", rd_data);
        end
        checks++;
        if (rd_busy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_rd_busy: got %b expected 00", rd_busy);
        end
        checks++;
        if (busy_cnt !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_busy_cnt: got %0d expected 0", busy_cnt);
        end
    endtask

    task automatic test_bypass_priority();
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 3; wr1_data = 32'h22;
        rd_addr = {5'd3, 5'd3};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h22 || rd_data[63:32] !== 32'h22) begin
            errors++;
            $display("[TB] FAIL bypass_same_cycle: got %h expected 22 on both ports", rd_data);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h22) begin
            errors++;
            $display("[TB] FAIL bypass_array: got %h expected 22", rd_data[31:0]);
        end
    endtask

    task automatic test_x0_protection();
        int cnt_before;
        cnt_before = exp_cnt();
        issue_en = 1; issue_addr = 0;
        wr0_en = 1; wr0_addr = 0; wr0_data = 32'hDEAD;
        rd_addr = {5'd0, 5'd0};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL x0_same_cycle: data %h busy %b expected 0/0", rd_data[31:0], rd_busy[0]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0 || int'(busy_cnt) != cnt_before) begin
            errors++;
            $display("[TB] FAIL x0_after: data %h busy %b cnt %0d expected 0/0/%0d",
                     rd_data[31:0], rd_busy[0], busy_cnt, cnt_before);
        end
    endtask

    task automatic test_scoreboard();
        issue_en = 1; issue_addr = 7;
        tick();
        idle_inputs();
        rd_addr = {5'd3, 5'd7};
        #1;
        checks++;
        if (busy_cnt !== 6'd1 || rd_busy !== 2'b01) begin
            errors++;
            $display("[TB] FAIL sb_issue: cnt %0d busy %b expected 1/01", busy_cnt, rd_busy);
        end
        wr0_en = 1; wr0_addr = 7; wr0_data = 32'h5;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h5) begin
            errors++;
            $display("[TB] FAIL sb_wb_bypass: busy %b data %h expected 0/5", rd_busy[0], rd_data[31:0]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (busy_cnt !== 6'd0 || rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h5) begin
            errors++;
            $display("[TB] FAIL sb_cleared: cnt %0d busy %b data %h expected 0/0/5",
                     busy_cnt, rd_busy[0], rd_data[31:0]);
        end
    endtask

    task automatic test_issue_collision();
        issue_en = 1; issue_addr = 9;
        tick();
        issue_en = 1; issue_addr = 9;
        wr1_en = 1; wr1_addr = 9; wr1_data = 32'h77;
        tick();
        idle_inputs();
        rd_addr = {5'd9, 5'd9};
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h77 || busy_cnt !== 6'd1) begin
            errors++;
            $display("[TB] FAIL collision: busy %b data %h cnt %0d expected 1/77/1",
                     rd_busy[0], rd_data[31:0], busy_cnt);
        end
    endtask

    task automatic test_flush_reset();
        for (int i = 1; i <= 3; i++) begin
            issue_en = 1; issue_addr = AW'(i);
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (busy_cnt !== 6'd4) begin
            errors++;
            $display("[TB] FAIL pre_flush_cnt: got %0d expected 4", busy_cnt);
        end
        flush = 1; issue_en = 1; issue_addr = 4;
        tick();
        idle_inputs();
        rd_addr = {5'd1, 5'd4};
        #1;
        checks++;
        if (busy_cnt !== 6'd1 || rd_busy !== 2'b01) begin
            errors++;
            $display("[TB] FAIL flush_issue: cnt %0d busy %b expected 1/01", busy_cnt, rd_busy);
        end
        rst_n = 0;
        wr0_en = 1; wr0_addr = 4; wr0_data = 32'h1234;
        rd_addr = {5'd7, 5'd4};
        #1;
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL read_in_reset: data %h busy %b expected 0/00", rd_data, rd_busy);
        end
        tick();
        rst_n = 1;
        idle_inputs();
        #1;
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00 || busy_cnt !== 6'd0) begin
            errors++;
            $display("[TB] FAIL after_reset: data %h busy %b cnt %0d expected 0/00/0",
                     rd_data, rd_busy, busy_cnt);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst_n      = ($urandom_range(0, 59) != 0);
            wr0_en     = $urandom_range(0, 1);
            wr0_addr   = AW'($urandom_range(0, 7));
            wr0_data   = $urandom;
            wr1_en     = ($urandom_range(0, 2) == 0);
            wr1_addr   = AW'($urandom_range(0, 7));
            wr1_data   = $urandom;
            issue_en   = $urandom_range(0, 1);
            issue_addr = AW'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 15) == 0);
            rd_addr    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            #1;
            for (int k = 0; k < NR; k++) begin
                logic [AW-1:0] a;
                logic [DW-1:0] ed;
                logic          eb;
                a  = rd_addr[k*AW +: AW];
                ed = exp_data(a);
                eb = exp_busy(a);
                checks++;
                if (rd_data[k*DW +: DW] !== ed || rd_busy[k] !== eb) begin
                    errors++;
                    $display("[TB] FAIL rand_read cyc %0d port %0d addr %0d: data %h busy %b expected %h/%b",
                             cyc, k, a, rd_data[k*DW +: DW], rd_busy[k], ed, eb);
                end
            end
            tick();
            checks++;
            if (int'(busy_cnt) != exp_cnt()) begin
                errors++;
                $display("[TB] FAIL rand_cnt cyc %0d: got %0d expected %0d", cyc, busy_cnt, exp_cnt());
            end
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
        end
        test_reset();
        test_bypass_priority();
        test_x0_protection();
        test_scoreboard();
        test_issue_collision();
        test_flush_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
